sysid_checker: RTL and testbench

Avalon-MM master that reads the system ID peripheral's control slave (word 0 = system ID, word 1 = build timestamp) after a start pulse and compares both words against values baked into the software build. It sits beside the Nios II boot path so firmware or a hardware monitor can confirm that the loaded image matches the FPGA configuration before enabling the camera pipeline. Results are held as sticky status flags until the next check.

---
 rtl/sysid_checker_if.sv | 25 ++
 rtl/sysid_checker.sv | 185 ++++++++++++++++++
 tb/tb_sysid_checker.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the
// system ID peripheral's control slave.
interface sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/sysid_checker.sv
// Reads sysid word 0 (ID) and word 1 (build timestamp) on a start pulse and
// holds sticky compare results against the build-time expected values.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1367819124,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  sysid_checker_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  id_ok,
  output logic                  ts_ok,
  output logic                  timeout,
  output logic [31:0]           id_value,
  output logic [31:0]           ts_value
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_REQ,
    ST_ID_WAIT,
    ST_TS_REQ,
    ST_TS_WAIT,
    ST_FIN
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic        w_expired;
  logic        w_clear;
  logic        w_cap_id;
  logic        w_cap_ts;
  logic        w_abort;

  logic        r_avm_read;
  logic        r_avm_address;
  logic        r_busy;
  logic        r_done;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

  // A transaction that slips past the limit (accepted on the expiry edge)
  // must still abort in WAIT, hence >= rather than ==.
  assign w_expired = (r_cnt >= TIMEOUT_LIMIT);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 16'd1;
    w_clear      = 1'b0;
    w_cap_id     = 1'b0;
    w_cap_ts     = 1'b0;
    w_abort      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (start) begin
          w_clear      = 1'b1;
          w_state_next = ST_ID_REQ;
        end
      end
      ST_ID_REQ: begin
        if (!bus.avm_waitrequest) begin
          w_state_next = ST_ID_WAIT;
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_state_next = ST_FIN;
        end
      end
      ST_ID_WAIT: begin
        if (bus.avm_readdatavalid) begin
          w_cap_id     = 1'b1;
          w_cnt_next   = '0;
          w_state_next = ST_TS_REQ;
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_state_next = ST_FIN;
        end
      end
      ST_TS_REQ: begin
        if (!bus.avm_waitrequest) begin
          w_state_next = ST_TS_WAIT;
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_state_next = ST_FIN;
        end
      end
      ST_TS_WAIT: begin
        if (bus.avm_readdatavalid) begin
          w_cap_ts     = 1'b1;
          w_state_next = ST_FIN;
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Bus and status outputs are registered from the next state, so they are
  // valid in the same cycle the FSM occupies that state.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous and clears every register, including the
    // captured words, so a stale ID can never be mistaken for a fresh one.
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_avm_read    <= 1'b0;
      r_avm_address <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_id_ok       <= 1'b0;
      r_ts_ok       <= 1'b0;
      r_timeout     <= 1'b0;
      r_id_value    <= '0;
      r_ts_value    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_avm_read    <= (w_state_next == ST_ID_REQ) || (w_state_next == ST_TS_REQ);
      r_avm_address <= (w_state_next == ST_TS_REQ);
      r_busy        <= (w_state_next != ST_IDLE);
      r_done        <= (w_state_next == ST_FIN);

      if (w_clear) begin
        r_id_ok    <= 1'b0;
        r_ts_ok    <= 1'b0;
        r_timeout  <= 1'b0;
        r_id_value <= '0;
        r_ts_value <= '0;
      end
      if (w_cap_id) begin
        r_id_value <= bus.avm_readdata;
        r_id_ok    <= (bus.avm_readdata == EXPECTED_ID);
      end
      if (w_cap_ts) begin
        r_ts_value <= bus.avm_readdata;
        r_ts_ok    <= (bus.avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (w_abort) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.avm_read    = r_avm_read;
  assign bus.avm_address = r_avm_address;
  assign busy            = r_busy;
  assign done            = r_done;
  assign id_ok           = r_id_ok;
  assign ts_ok           = r_ts_ok;
  assign timeout         = r_timeout;
  assign id_value        = r_id_value;
  assign ts_value        = r_ts_value;

  // A stalled request must hold address and read until the slave accepts it.
  a_req_stable: assert property (@(posedge clock) disable iff (!reset_n)
    ((r_state == ST_ID_REQ) || (r_state == ST_TS_REQ)) && bus.avm_waitrequest && !w_expired
    |=> $stable(r_avm_read) && $stable(r_avm_address));

  a_done_pulse: assert property (@(posedge clock) disable iff (!reset_n)
    r_done |=> !r_done);

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: reactive sysid slave, timeline model of each check
// compared every cycle, plus directed scenarios with hand-computed results.
module tb_sysid_checker;
  localparam int          TMO    = 10;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1367819124;
  localparam int          NONE   = 1000000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  sysid_checker_if bus ();

  sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .clock    (clk),
    .reset_n  (rst_n),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .id_ok    (id_ok),
    .ts_ok    (ts_ok),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge; "after edge e" names a cycle.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  // ---------------- slave model ----------------
  int          ws [2];
  int          dl [2];
  logic        stuck [2];
  logic [31:0] words [2];
  int          stray_at = -10;
  logic [31:0] stray_data = 32'h0;

  initial begin
    int          stall;
    int          rdv_at;
    logic        in_req;
    logic [31:0] pend_data;
    int          a;
    stall = 0; rdv_at = -10; in_req = 1'b0; pend_data = '0; a = 0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      if (edge_n == rdv_at) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = pend_data;
      end else if (edge_n == stray_at) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = stray_data;
      end else begin
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
      end
      if (bus.avm_read) begin
        a = bus.avm_address ? 1 : 0;
        if (!in_req) begin
          in_req = 1'b1;
          stall  = stuck[a] ? 1000000 : ws[a];
        end
        if (stall > 0) begin
          bus.avm_waitrequest = 1'b1;
          stall--;
        end else begin
          bus.avm_waitrequest = 1'b0;
          in_req    = 1'b0;
          rdv_at    = edge_n + 1 + dl[a];
          pend_data = words[a];
        end
      end else begin
        bus.avm_waitrequest = 1'b0;
        in_req = 1'b0;
      end
    end
  end

  // ---------------- check timeline model ----------------
  // s: start edge, a*: acceptance edges, c*: capture edges, d: done edge.
  typedef struct {
    int          s, a1, c1, a2, c2, d;
    logic [31:0] f_id_v, f_ts_v, p_id_v, p_ts_v;
    logic        f_id_ok, f_ts_ok, f_to, p_id_ok, p_ts_ok, p_to;
  } rec_t;

  function automatic rec_t reset_rec();
    rec_t r;
    r.s = NONE; r.a1 = NONE; r.c1 = NONE; r.a2 = NONE; r.c2 = NONE; r.d = NONE;
    r.f_id_v = '0; r.f_ts_v = '0; r.p_id_v = '0; r.p_ts_v = '0;
    r.f_id_ok = 0; r.f_ts_ok = 0; r.f_to = 0; r.p_id_ok = 0; r.p_ts_ok = 0; r.p_to = 0;
    return r;
  endfunction

  function automatic rec_t plan(input int s, input int ws_id, input int dl_id,
                                input int ws_ts, input int dl_ts, input logic stk,
                                input logic [31:0] wid, input logic [31:0] wts,
                                input rec_t old);
    rec_t r;
    r = reset_rec();
    if (old.s == NONE) begin
      r.p_id_v = old.p_id_v; r.p_ts_v = old.p_ts_v;
      r.p_id_ok = old.p_id_ok; r.p_ts_ok = old.p_ts_ok; r.p_to = old.p_to;
    end else begin
      r.p_id_v = old.f_id_v; r.p_ts_v = old.f_ts_v;
      r.p_id_ok = old.f_id_ok; r.p_ts_ok = old.f_ts_ok; r.p_to = old.f_to;
    end
    r.s = s;
    if (stk) begin
      r.d    = s + TMO + 1;
      r.f_to = 1'b1;
    end else begin
      r.a1 = s + 1 + ws_id;
      r.c1 = r.a1 + 1 + dl_id;
      r.a2 = r.c1 + 1 + ws_ts;
      r.c2 = r.a2 + 1 + dl_ts;
      r.d  = r.c2;
      r.f_id_v = wid; r.f_id_ok = (wid == EXP_ID);
      r.f_ts_v = wts; r.f_ts_ok = (wts == EXP_TS);
    end
    return r;
  endfunction

  rec_t rec;
  logic cmp_en = 1'b0;

  int          e;
  logic        x_busy, x_done, x_rd, x_addr, x_idok, x_tsok, x_to;
  logic [31:0] x_idv, x_tsv;

  always @(negedge clk) begin
    if (cmp_en) begin
      e = edge_n;
      if (e < rec.s) begin
        x_busy = 0; x_done = 0; x_rd = 0; x_addr = 0;
        x_idv = rec.p_id_v; x_idok = rec.p_id_ok;
        x_tsv = rec.p_ts_v; x_tsok = rec.p_ts_ok; x_to = rec.p_to;
      end else begin
        x_busy = (e <= rec.d);
        x_done = (e == rec.d);
        x_rd   = (e < rec.d) && ((e < rec.a1) || (e >= rec.c1 && e < rec.a2));
        x_addr = (e >= rec.c1);
        x_idv  = (e >= rec.c1) ? rec.f_id_v : 32'h0;
        x_idok = (e >= rec.c1) ? rec.f_id_ok : 1'b0;
        x_tsv  = (e >= rec.c2) ? rec.f_ts_v : 32'h0;
        x_tsok = (e >= rec.c2) ? rec.f_ts_ok : 1'b0;
        x_to   = (e >= rec.d) && rec.f_to;
      end
      check("busy", busy, x_busy);
      check("done", done, x_done);
      check("avm_read", bus.avm_read, x_rd);
      if (x_rd) check("avm_address", bus.avm_address, x_addr);
      check("id_value", id_value, x_idv);
      check("id_ok", id_ok, x_idok);
      check("ts_value", ts_value, x_tsv);
      check("ts_ok", ts_ok, x_tsok);
      check("timeout", timeout, x_to);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cfg(input int wsi, input int dli, input int wst, input int dlt,
                     input logic stk, input logic [31:0] wid, input logic [31:0] wts);
    ws[0] = wsi; dl[0] = dli; ws[1] = wst; dl[1] = dlt;
    stuck[0] = stk; stuck[1] = 1'b0;
    words[0] = wid; words[1] = wts;
  endtask

  // Called just after a falling edge with the DUT idle; returns at the
  // falling edge after the start edge.
  task automatic launch(input int wsi, input int dli, input int wst, input int dlt,
                        input logic stk, input logic [31:0] wid, input logic [31:0] wts);
    cfg(wsi, dli, wst, dlt, stk, wid, wts);
    rec   = plan(edge_n + 1, wsi, dli, wst, dlt, stk, wid, wts, rec);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int n_rd1);
    lat   = -1;
    n_rd1 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.avm_read && bus.avm_address) n_rd1++;
      if (done) begin
        lat = edge_n - rec.s;
        break;
      end
    end
    if (lat < 0) check("done_seen", done, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int lat, n_rd1, n_extra, guard;
    int b2b_lat [3];
    rst_n = 1'b0;
    start = 1'b0;
    cfg(0, 0, 0, 0, 1'b0, EXP_ID, EXP_TS);
    rec = reset_rec();
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_avm_read", bus.avm_read, 0);
    check("rst_id_value", id_value, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Matching image, no stalls.
    launch(0, 0, 0, 0, 1'b0, EXP_ID, EXP_TS);
    wait_done(lat, n_rd1);
    check("basic_latency", lat, 4);
    check("basic_id_ok", id_ok, 1);
    check("basic_ts_ok", ts_ok, 1);
    check("basic_timeout", timeout, 0);
    check("basic_ts_value", ts_value, 32'd1367819124);
    repeat (2) @(negedge clk);

    // Timestamp off by one, three stall cycles on the word-1 read.
    launch(0, 0, 3, 0, 1'b0, EXP_ID, 32'd1367819125);
    wait_done(lat, n_rd1);
    check("stall_latency", lat, 7);
    check("stall_rd1_cycles", n_rd1, 4);
    check("stall_id_ok", id_ok, 1);
    check("stall_ts_ok", ts_ok, 0);
    check("stall_ts_value", ts_value, 32'd1367819125);
    repeat (2) @(negedge clk);

    // Slave never releases waitrequest on the ID read.
    launch(0, 0, 0, 0, 1'b1, EXP_ID, EXP_TS);
    wait_done(lat, n_rd1);
    check("tmo_latency", lat, 11);
    check("tmo_timeout", timeout, 1);
    check("tmo_id_ok", id_ok, 0);
    check("tmo_ts_ok", ts_ok, 0);
    check("tmo_avm_read", bus.avm_read, 0);
    cfg(0, 0, 0, 0, 1'b0, EXP_ID, EXP_TS);
    repeat (2) @(negedge clk);

    // Second start mid-check, wrong ID, then stray readdatavalid while idle.
    launch(0, 1, 0, 0, 1'b0, 32'hDEAD_0001, EXP_TS);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, n_rd1);
    check("mid_latency", lat, 5);
    check("mid_id_ok", id_ok, 0);
    check("mid_id_value", id_value, 32'hDEAD_0001);
    n_extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) n_extra++;
    end
    check("mid_extra_done", n_extra, 0);
    stray_data = 32'hCAFE_F00D;
    stray_at   = edge_n + 1;
    repeat (3) @(negedge clk);
    check("stray_id_value", id_value, 32'hDEAD_0001);
    check("stray_busy", busy, 0);

    // One-edge reset while waiting for word 1; its data arrives late.
    launch(0, 0, 0, 2, 1'b0, 32'h1111_2222, EXP_TS);
    guard = 0;
    while (edge_n < rec.a2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rec = reset_rec();
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_id_value", id_value, 0);
    check("rst_mid_avm_read", bus.avm_read, 0);
    repeat (4) @(negedge clk);
    check("rst_late_ts_value", ts_value, 0);
    check("rst_late_busy", busy, 0);

    // start held high: back-to-back checks with one idle cycle between.
    b2b_lat[0] = 4;
    b2b_lat[1] = 6;
    b2b_lat[2] = 8;
    @(negedge clk);
    cfg(0, 0, 0, 0, 1'b0, EXP_ID, EXP_TS);
    rec   = plan(edge_n + 1, 0, 0, 0, 0, 1'b0, EXP_ID, EXP_TS, rec);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(lat, n_rd1);
      check("b2b_latency", lat, b2b_lat[k]);
      if (k < 2) begin
        @(negedge clk);
        check("b2b_gap_read", bus.avm_read, 0);
        check("b2b_gap_busy", busy, 0);
        if (k == 0) begin
          cfg(1, 0, 0, 1, 1'b0, EXP_ID, EXP_TS);
          rec = plan(rec.d + 2, 1, 0, 0, 1, 1'b0, EXP_ID, EXP_TS, rec);
        end else begin
          cfg(0, 2, 2, 0, 1'b0, 32'h0000_0007, EXP_TS);
          rec = plan(rec.d + 2, 0, 2, 2, 0, 1'b0, 32'h0000_0007, EXP_TS, rec);
        end
        @(negedge clk);
        check("b2b_next_read", bus.avm_read, 1);
      end else begin
        start = 1'b0;
      end
    end
    check("b2b_last_id_ok", id_ok, 0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at edge %0d", edge_n);
    $fatal(1);
  end

endmodule
